// File: rtl/imem_fetch_resp.sv
// Instruction memory with a one-cycle synchronous read stage feeding a 2-entry in-order response FIFO.
// Optional macro IMEM_ALIGN_CHECK_EN: flag odd fetch addresses on rsp_err (otherwise rsp_err is tied 0).
module imem_fetch_resp #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] req_addr,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          flush,
    output logic [DW-1:0] rsp_instr,
    output logic [AW-1:0] rsp_addr,
    output logic          rsp_err,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);
    localparam int DEPTH = 1 << (AW - 1);

    logic [DW-1:0] mem [DEPTH];

    logic [DW-1:0] s1_instr;
    logic          s1_valid;
    logic [AW-1:0] s1_addr;

    logic [DW-1:0] fifo_instr [2];
    logic [AW-1:0] fifo_addr  [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    fifo_count;

    logic accept;
    logic push;
    logic pop;
    logic unused_addr_bits;

    // Handshakes: a request transfers when req_valid && req_ready, a response when
    // rsp_valid && rsp_ready. The read stage counts against FIFO capacity, so every
    // accepted fetch is guaranteed a buffer slot when its read data arrives.
    assign req_ready = reset && !flush && ((fifo_count + {1'b0, s1_valid}) < 2'd2);
    assign accept    = req_valid && req_ready;
    assign push      = s1_valid;
    assign rsp_valid = (fifo_count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;

    assign rsp_instr = fifo_instr[rd_ptr];
    assign rsp_addr  = fifo_addr[rd_ptr];

    assign unused_addr_bits = wr_addr[0] ^ req_addr[0];

    // Memory is never reset; a same-index write and read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[AW-1:1]] <= wr_data;
        end
        s1_instr <= mem[req_addr[AW-1:1]];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid      <= 1'b0;
            s1_addr       <= '0;
            fifo_count    <= 2'd0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_instr[0] <= '0;
            fifo_instr[1] <= '0;
            fifo_addr[0]  <= '0;
            fifo_addr[1]  <= '0;
        end else if (flush) begin
            // A pop coinciding with flush is still a handshake; its entry simply vanishes.
            s1_valid   <= 1'b0;
            fifo_count <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr <= req_addr;
            end
            if (push) begin
                fifo_instr[wr_ptr] <= s1_instr;
                fifo_addr[wr_ptr]  <= s1_addr;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef IMEM_ALIGN_CHECK_EN
    logic s1_err;
    logic fifo_err [2];

    // The error bit rides alongside the data; the read itself ignores addr[0].
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_err      <= 1'b0;
            fifo_err[0] <= 1'b0;
            fifo_err[1] <= 1'b0;
        end else if (!flush) begin
            if (accept) begin
                s1_err <= req_addr[0];
            end
            if (push) begin
                fifo_err[wr_ptr] <= s1_err;
            end
        end
    end

    assign rsp_err = fifo_err[rd_ptr];
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Self-checking bench for imem_fetch_resp: directed scenarios plus a randomized run
// against a queue-based reference model (capacity 2, two-cycle response latency).
module tb_imem_fetch_resp;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int EW = 1 + AW + DW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          flush = 1'b0;
    logic [DW-1:0] rsp_instr;
    logic [AW-1:0] rsp_addr;
    logic          rsp_err;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;

    always #5 clk = ~clk;

    imem_fetch_resp #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req_addr(req_addr), .req_valid(req_valid),
        .req_ready(req_ready), .flush(flush), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
        .rsp_err(rsp_err), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // ---------------- reference model / scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] model_mem [1 << (AW-1)];
    logic [EW-1:0] exp_q[$];   // {err, addr, instr} of accepted, not yet consumed fetches
    int            due_q[$];   // earliest cycle each entry may be presented

    logic          obs_req_ready, obs_rsp_valid, obs_rsp_err;
    logic [DW-1:0] obs_instr;
    logic [AW-1:0] obs_addr;
    logic          exp_req_ready, exp_rsp_valid, exp_accept, exp_pop;
    logic [EW-1:0] exp_head;

    function automatic logic exp_err_of(input logic [AW-1:0] a);
`ifdef IMEM_ALIGN_CHECK_EN
        return a[0];
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle of inputs, samples outputs at the falling edge, advances the model.
    task automatic step(input logic rst_n, input logic rv, input logic [AW-1:0] ra,
                        input logic fl, input logic rr, input logic we,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        reset = rst_n; req_valid = rv; req_addr = ra; flush = fl;
        rsp_ready = rr; wr_en = we; wr_addr = wa; wr_data = wd;
        @(negedge clk);
        obs_req_ready = req_ready;
        obs_rsp_valid = rsp_valid;
        obs_instr     = rsp_instr;
        obs_addr      = rsp_addr;
        obs_rsp_err   = rsp_err;
        exp_req_ready = rst_n && !fl && (exp_q.size() < 2);
        exp_rsp_valid = (exp_q.size() > 0) && (due_q[0] <= cyc);
        exp_accept    = rv && exp_req_ready;
        exp_pop       = exp_rsp_valid && rr;
        exp_head      = (exp_q.size() > 0) ? exp_q[0] : '0;
        if (!rst_n || fl) begin
            exp_q.delete();
            due_q.delete();
        end else begin
            if (exp_pop) begin
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            if (exp_accept) begin
                exp_q.push_back({exp_err_of(ra), ra, model_mem[ra[AW-1:1]]});
                due_q.push_back(cyc + 2);
            end
        end
        if (we) model_mem[wa[AW-1:1]] = wd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    // Issues one request and waits for its response (queue assumed empty on entry).
    task automatic fetch_one(input logic [AW-1:0] a, output logic ok,
                             output logic [DW-1:0] ins, output logic [AW-1:0] ad, output logic er);
        logic sent;
        sent = 1'b0; ok = 1'b0; ins = 'x; ad = 'x; er = 1'bx;
        for (int k = 0; k < 20 && !ok; k++) begin
            step(1'b1, !sent, a, 1'b0, 1'b1, 1'b0, '0, '0);
            if (sent && obs_rsp_valid) begin
                ok = 1'b1; ins = obs_instr; ad = obs_addr; er = obs_rsp_err;
            end
            if (!sent && obs_req_ready) sent = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        checks++; if (obs_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", obs_req_ready); end
        checks++; if (obs_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", obs_rsp_valid); end
        checks++; if (obs_instr !== 16'h0 || obs_addr !== 10'd0 || obs_rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got instr %h addr %0d err %b want 0 0 0", obs_instr, obs_addr, obs_rsp_err);
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        checks++; if (obs_req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", obs_req_ready); end
    endtask

    task automatic load_program();
        logic [DW-1:0] prog [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, AW'(2 * i), (i < 4) ? prog[i] : DW'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] want [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        int sent = 0, got = 0, first_acc = -1, first_rsp = -1;
        for (int k = 0; k < 40 && got < 4; k++) begin
            step(1'b1, sent < 4, AW'(2 * sent), 1'b0, 1'b1, 1'b0, '0, '0);
            checks++; if (obs_req_ready !== exp_req_ready) begin errors++; $display("FAIL b2b_req_ready cyc %0d: got %b want %b", cyc - 1, obs_req_ready, exp_req_ready); end
            checks++; if (obs_rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL b2b_rsp_valid cyc %0d: got %b want %b", cyc - 1, obs_rsp_valid, exp_rsp_valid); end
            if (exp_accept) begin
                if (first_acc < 0) first_acc = cyc - 1;
                sent++;
            end
            if (exp_pop) begin
                if (first_rsp < 0) first_rsp = cyc - 1;
                checks++;
                if (obs_instr !== want[got] || obs_addr !== AW'(2 * got)) begin
                    errors++; $display("FAIL b2b_data #%0d: got %h@%0d want %h@%0d", got, obs_instr, obs_addr, want[got], 2 * got);
                end
                got++;
            end
        end
        checks++; if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d responses want 4", got); end
        checks++; if (first_rsp - first_acc != 2) begin errors++; $display("FAIL b2b_latency: got %0d want 2", first_rsp - first_acc); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] want [3] = '{16'h1111, 16'h2222, 16'h3333};
        int acc = 0, got = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, AW'(2 * acc), 1'b0, 1'b0, 1'b0, '0, '0);
            if (obs_req_ready) acc++;
        end
        checks++; if (acc != 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", acc); end
        checks++; if (obs_req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready_full: got %b want 0", obs_req_ready); end
        for (int k = 0; k < 20 && got < 3; k++) begin
            step(1'b1, acc < 3, AW'(2 * acc), 1'b0, 1'b1, 1'b0, '0, '0);
            if (obs_rsp_valid) begin
                checks++;
                if (obs_instr !== want[got] || obs_addr !== AW'(2 * got)) begin
                    errors++; $display("FAIL bp_data #%0d: got %h@%0d want %h@%0d", got, obs_instr, obs_addr, want[got], 2 * got);
                end
                got++;
            end
            if (obs_req_ready && acc < 3) acc++;
        end
        checks++; if (acc != 3 || got != 3) begin errors++; $display("FAIL bp_drain: got acc %0d rsp %0d want 3 3", acc, got); end
        idle(3);
    endtask

    task automatic test_flush();
        logic ok, er;
        logic [DW-1:0] ins;
        logic [AW-1:0] ad;
        step(1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 10'd2, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 10'd4, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (obs_req_ready !== 1'b0) begin errors++; $display("FAIL flush_req_ready: got %b want 0", obs_req_ready); end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
            checks++; if (obs_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_stale_rsp cyc %0d: got %b want 0", cyc - 1, obs_rsp_valid); end
        end
        fetch_one(10'd6, ok, ins, ad, er);
        checks++; if (!ok || ins !== 16'h4444 || ad !== 10'd6) begin errors++; $display("FAIL flush_refetch: got ok %b %h@%0d want 1 4444@6", ok, ins, ad); end
        // flush while a response is being consumed
        step(1'b1, 1'b1, 10'd0, 1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0, '0);
        checks++; if (obs_rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_pop_valid: got %b want 1", obs_rsp_valid); end
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        checks++; if (obs_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_pop_after: got %b want 0", obs_rsp_valid); end
    endtask

    task automatic test_align();
        logic ok, er;
        logic [DW-1:0] ins;
        logic [AW-1:0] ad;
        fetch_one(10'd3, ok, ins, ad, er);
        checks++; if (!ok || ins !== 16'h2222 || ad !== 10'd3) begin errors++; $display("FAIL align_data: got ok %b %h@%0d want 1 2222@3", ok, ins, ad); end
`ifdef IMEM_ALIGN_CHECK_EN
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL align_err: got %b want 1", er); end
`else
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL align_err: got %b want 0", er); end
`endif
    endtask

    task automatic test_write_collision();
        logic ok, er;
        logic [DW-1:0] ins;
        logic [AW-1:0] ad;
        int got = 0;
        step(1'b1, 1'b1, 10'd2, 1'b0, 1'b1, 1'b1, 10'd2, 16'hBEEF);
        checks++; if (obs_req_ready !== 1'b1) begin errors++; $display("FAIL wr_coll_accept: got %b want 1", obs_req_ready); end
        for (int k = 0; k < 10 && got == 0; k++) begin
            step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
            if (obs_rsp_valid) begin
                got = 1;
                checks++; if (obs_instr !== 16'h2222) begin errors++; $display("FAIL wr_coll_old: got %h want 2222", obs_instr); end
            end
        end
        checks++; if (got != 1) begin errors++; $display("FAIL wr_coll_timeout: got %0d responses want 1", got); end
        fetch_one(10'd2, ok, ins, ad, er);
        checks++; if (!ok || ins !== 16'hBEEF) begin errors++; $display("FAIL wr_coll_new: got ok %b %h want 1 beef", ok, ins); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] want [4] = '{16'h1111, 16'hBEEF, 16'h3333, 16'h4444};
        logic ok, er;
        logic [DW-1:0] ins;
        logic [AW-1:0] ad;
        step(1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 10'd2, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        checks++; if (obs_rsp_valid !== 1'b1 || obs_req_ready !== 1'b0) begin errors++; $display("FAIL rmid_full: got valid %b ready %b want 1 0", obs_rsp_valid, obs_req_ready); end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        checks++; if (obs_req_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset: got %b want 0", obs_req_ready); end
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        checks++; if (obs_rsp_valid !== 1'b0 || obs_instr !== 16'h0 || obs_addr !== 10'd0 || obs_rsp_err !== 1'b0 || obs_req_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_outputs: got v%b %h@%0d e%b r%b want v0 0000@0 e0 r1", obs_rsp_valid, obs_instr, obs_addr, obs_rsp_err, obs_req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            fetch_one(AW'(2 * i), ok, ins, ad, er);
            checks++; if (!ok || ins !== want[i]) begin errors++; $display("FAIL rmid_mem #%0d: got ok %b %h want 1 %h", i, ok, ins, want[i]); end
        end
    endtask

    task automatic test_random();
        logic rst_n, rv, fl, rr, we;
        logic [AW-1:0] ra, wa;
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            rv    = ($urandom_range(0, 3) != 0);
            ra    = AW'($urandom_range(0, 31));
            fl    = ($urandom_range(0, 15) == 0);
            rr    = ($urandom_range(0, 2) != 0);
            we    = ($urandom_range(0, 7) == 0);
            wa    = AW'($urandom_range(0, 31));
            step(rst_n, rv, ra, fl, rr, we, wa, DW'($urandom));
            checks++; if (obs_req_ready !== exp_req_ready) begin errors++; $display("FAIL rnd_req_ready cyc %0d: got %b want %b", cyc - 1, obs_req_ready, exp_req_ready); end
            checks++; if (obs_rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL rnd_rsp_valid cyc %0d: got %b want %b", cyc - 1, obs_rsp_valid, exp_rsp_valid); end
            if (exp_rsp_valid) begin
                checks++;
                if (obs_instr !== exp_head[DW-1:0] || obs_addr !== exp_head[AW+DW-1:DW] || obs_rsp_err !== exp_head[EW-1]) begin
                    errors++; $display("FAIL rnd_payload cyc %0d: got %h@%0d e%b want %h@%0d e%b", cyc - 1,
                                       obs_instr, obs_addr, obs_rsp_err, exp_head[DW-1:0], exp_head[AW+DW-1:DW], exp_head[EW-1]);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        load_program();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_align();
        test_write_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
